// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
// Read-side scheduler for a bank of N_PORTS FIFOs. Grants one non-empty FIFO
// at a time for bursts of up to MAX_BURST words. Each word goes through
// RD (pulse rd_en), CAP (capture the returned word) and OUT (hold until the
// consumer accepts it). Output is a single valid/ready channel tagged with
// the source port.
//
// Optional build macro: FIFO_SCHED_PRIO_EN
//   defined   : fixed-priority arbitration; lowest-index non-empty port wins,
//               rr_ptr is held at 0.
//   undefined : round-robin arbitration starting from rr_ptr.
module fifo_rr_scheduler #(
    parameter int N_PORTS   = 4,
    parameter int W_WIDTH   = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en,
    input  logic [N_PORTS-1:0]         fifo_empty,
    input  logic [N_PORTS*W_WIDTH-1:0] fifo_data,
    output logic [N_PORTS-1:0]         fifo_rd_en,
    output logic [W_WIDTH-1:0]         out_data,
    output logic [$clog2(N_PORTS)-1:0] out_port,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int PW = $clog2(N_PORTS);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] grant;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] arb_grant;
    logic [PW-1:0] grant_inc;
    logic [BW-1:0] burst_cnt;
    logic          arb_found;
    logic          burst_more;
    logic          handshake;

    logic [W_WIDTH-1:0] port_data [N_PORTS];

    // Split the concatenated FIFO data bus into one word per port.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_split
        assign port_data[gi] = fifo_data[gi*W_WIDTH +: W_WIDTH];
    end

    // Arbitration: first non-empty port searching upward from rr_ptr.
    // With FIFO_SCHED_PRIO_EN rr_ptr stays 0, so this is lowest-index-first.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        arb_found = 1'b0;
        arb_grant = '0;
        idx       = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N_PORTS);
            if (!arb_found && !fifo_empty[idx]) begin
                arb_found = 1'b1;
                arb_grant = idx;
            end
        end
    end

    // Burst continuation and pointer-advance helpers.
    always_comb begin
        grant_inc  = (grant == PW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
        burst_more = sched_en && !fifo_empty[grant] && (burst_cnt < BW'(MAX_BURST));
        handshake  = (state == OUT) && out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sched_en && arb_found) state_next = RD;
            RD:      state_next = CAP;
            CAP:     state_next = OUT;
            OUT:     if (handshake) state_next = burst_more ? RD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state: read strobe in RD, busy outside IDLE.
    always_comb begin
        fifo_rd_en = '0;
        if ((state == RD) && !fifo_empty[grant]) fifo_rd_en[grant] = 1'b1;
        busy = (state != IDLE);
    end

    // Grant, pointer, burst counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            out_data  <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sched_en && arb_found) begin
                        grant     <= arb_grant;
                        burst_cnt <= '0;
                    end
                end
                CAP: begin
                    out_data  <= port_data[grant];
                    out_port  <= grant;
                    out_valid <= 1'b1;
                    burst_cnt <= burst_cnt + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!burst_more) begin
`ifdef FIFO_SCHED_PRIO_EN
                            rr_ptr <= '0;
`else
                            rr_ptr <= grant_inc;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler (N_PORTS=4, W_WIDTH=32,
// MAX_BURST=4). A small behavioural FIFO bank feeds the DUT; a negedge
// collector logs accepted words and read strobes for the scenario tasks.
module tb_fifo_rr_scheduler;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int LOGN  = 2;
    localparam int DEPTH = 64;
    localparam int LOGSZ = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            sched_en;
    logic [N-1:0]    fifo_empty;
    logic [N*W-1:0]  fifo_data;
    logic [N-1:0]    fifo_rd_en;
    logic [W-1:0]    out_data;
    logic [LOGN-1:0] out_port;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(.N_PORTS(N), .W_WIDTH(W), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // Behavioural FIFO bank: data_out and empty update on the read edge.
    logic [W-1:0] mem [N][DEPTH];
    logic [W-1:0] dout [N];
    int rd_ptr [N];
    int wr_ptr [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_rd_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
                dout[i]   <= mem[i][rd_ptr[i] % DEPTH];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_fifo
        assign fifo_empty[g]       = (rd_ptr[g] == wr_ptr[g]);
        assign fifo_data[g*W +: W] = dout[g];
    end

    // Cycle counter and collector of handshakes, read strobes and protocol violations.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0]    got_data [LOGSZ];
    logic [LOGN-1:0] got_port [LOGSZ];
    int got_cyc [LOGSZ];
    int rd_cyc  [LOGSZ];
    int rd_port [LOGSZ];
    int got_n = 0;
    int rd_n  = 0;
    int viol  = 0;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_data[got_n % LOGSZ] <= out_data;
            got_port[got_n % LOGSZ] <= out_port;
            got_cyc[got_n % LOGSZ]  <= cyc;
            got_n <= got_n + 1;
        end
        if (fifo_rd_en !== '0) begin
            rd_cyc[rd_n % LOGSZ]  <= cyc;
            rd_port[rd_n % LOGSZ] <= oh_idx(fifo_rd_en);
            rd_n <= rd_n + 1;
        end
        if (!$onehot0(fifo_rd_en) || ((fifo_rd_en & fifo_empty) !== '0)) viol <= viol + 1;
    end

    function automatic logic [W-1:0] mkw(input logic [7:0] tag, input int p, input int k);
        return {tag, 8'(p), 16'(k)};
    endfunction

    task automatic push(input int p, input logic [W-1:0] w);
        mem[p][wr_ptr[p] % DEPTH] = w;
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int target, input int budget, input string name);
        for (int c = 0; c < budget && got_n < target; c++) step();
        n_total++;
        if (got_n < target) $display("FAIL %s: got %0d words expected %0d (timeout)", name, got_n, target);
        else n_pass++;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int c = 0; c < budget && busy !== 1'b0; c++) step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s: busy got %b expected 0 (timeout)", name, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sched_en = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (fifo_rd_en !== 4'b0000) $display("FAIL reset_rd_en: got %b expected 0000", fifo_rd_en); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 00000000", out_data); else n_pass++;
        n_total++; if (out_port !== 2'd0) $display("FAIL reset_out_port: got %0d expected 0", out_port); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    endtask

    // rr_ptr=0: 0,1,2,3 x4 words, then 0,1,2,3 x2 words.
    task automatic test_all_ports();
        int g0, r0, idx;
        logic [W-1:0] exp_w;
        sched_en = 1'b0; out_ready = 1'b1;
        for (int p = 0; p < N; p++) for (int k = 0; k < 6; k++) push(p, mkw(8'h11, p, k));
        g0 = got_n; r0 = rd_n;
        sched_en = 1'b1;
        wait_words(g0 + 24, 400, "all_ports_done");
        wait_idle(20, "all_ports_idle");
        idx = g0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                for (int j = 0; j < ((r == 0) ? 4 : 2); j++) begin
                    exp_w = mkw(8'h11, p, r*4 + j);
                    n_total++;
                    if (got_port[idx % LOGSZ] !== LOGN'(p) || got_data[idx % LOGSZ] !== exp_w)
                        $display("FAIL all_ports_word%0d: got port %0d data %h expected port %0d data %h",
                                 idx - g0, got_port[idx % LOGSZ], got_data[idx % LOGSZ], p, exp_w);
                    else n_pass++;
                    idx++;
                end
            end
        end
        n_total++; if (rd_n - r0 != 24) $display("FAIL all_ports_reads: got %0d expected 24", rd_n - r0); else n_pass++;
    endtask

    // Port 2 only, 3 words: reads 3 cycles apart, 2-cycle rd->valid latency.
    task automatic test_single_port();
        int g0, r0, c_en;
        sched_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) push(2, 32'hA000_0000 + k);
        g0 = got_n; r0 = rd_n;
        c_en = cyc;
        sched_en = 1'b1;
        wait_words(g0 + 3, 60, "single_done");
        wait_idle(20, "single_idle");
        n_total++; if (rd_n - r0 != 3) $display("FAIL single_reads: got %0d expected 3", rd_n - r0); else n_pass++;
        n_total++; if (rd_cyc[r0 % LOGSZ] != c_en + 1) $display("FAIL single_arb_latency: got %0d expected %0d", rd_cyc[r0 % LOGSZ] - c_en, 1); else n_pass++;
        n_total++; if (got_cyc[g0 % LOGSZ] - rd_cyc[r0 % LOGSZ] != 2) $display("FAIL single_valid_latency: got %0d expected 2", got_cyc[g0 % LOGSZ] - rd_cyc[r0 % LOGSZ]); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (rd_port[(r0 + k) % LOGSZ] != 2) $display("FAIL single_rd_port%0d: got %0d expected 2", k, rd_port[(r0 + k) % LOGSZ]);
            else n_pass++;
            n_total++;
            if (got_port[(g0 + k) % LOGSZ] !== 2'd2 || got_data[(g0 + k) % LOGSZ] !== 32'hA000_0000 + k)
                $display("FAIL single_word%0d: got port %0d data %h expected port 2 data %h",
                         k, got_port[(g0 + k) % LOGSZ], got_data[(g0 + k) % LOGSZ], 32'hA000_0000 + k);
            else n_pass++;
        end
        for (int k = 1; k < 3; k++) begin
            n_total++;
            if (rd_cyc[(r0 + k) % LOGSZ] - rd_cyc[(r0 + k - 1) % LOGSZ] != 3)
                $display("FAIL single_spacing%0d: got %0d expected 3", k, rd_cyc[(r0 + k) % LOGSZ] - rd_cyc[(r0 + k - 1) % LOGSZ]);
            else n_pass++;
        end
    endtask

    // rr_ptr=3 after the port-2 burst: port 1 wins, sched_en drops in RD.
    task automatic test_sched_en_drop();
        int g0, r0;
        logic [W-1:0] exp_w [5];
        logic [LOGN-1:0] exp_p [5];
        sched_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1, mkw(8'h51, 1, k));
            push(2, mkw(8'h52, 2, k));
        end
        g0 = got_n; r0 = rd_n;
        sched_en = 1'b1;
        step();
        sched_en = 1'b0;
        repeat (15) step();
        n_total++; if (got_n - g0 != 1) $display("FAIL drop_words: got %0d expected 1", got_n - g0); else n_pass++;
        n_total++;
        if (got_port[g0 % LOGSZ] !== 2'd1 || got_data[g0 % LOGSZ] !== mkw(8'h51, 1, 0))
            $display("FAIL drop_first_word: got port %0d data %h expected port 1 data %h",
                     got_port[g0 % LOGSZ], got_data[g0 % LOGSZ], mkw(8'h51, 1, 0));
        else n_pass++;
        n_total++; if (rd_n - r0 != 1) $display("FAIL drop_reads_disabled: got %0d expected 1", rd_n - r0); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy); else n_pass++;
        exp_w = '{mkw(8'h52, 2, 0), mkw(8'h52, 2, 1), mkw(8'h52, 2, 2), mkw(8'h51, 1, 1), mkw(8'h51, 1, 2)};
        exp_p = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        sched_en = 1'b1;
        wait_words(g0 + 6, 100, "drop_resume_done");
        wait_idle(20, "drop_resume_idle");
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (got_port[(g0 + 1 + k) % LOGSZ] !== exp_p[k] || got_data[(g0 + 1 + k) % LOGSZ] !== exp_w[k])
                $display("FAIL drop_resume_word%0d: got port %0d data %h expected port %0d data %h",
                         k, got_port[(g0 + 1 + k) % LOGSZ], got_data[(g0 + 1 + k) % LOGSZ], exp_p[k], exp_w[k]);
            else n_pass++;
        end
    endtask

    // Port 1, 2 words, consumer stalls 5 cycles on the first word.
    task automatic test_backpressure();
        int g0, r0;
        sched_en = 1'b0; out_ready = 1'b0;
        push(1, 32'hB000_0010);
        push(1, 32'hB000_0011);
        g0 = got_n;
        sched_en = 1'b1;
        for (int c = 0; c < 20 && out_valid !== 1'b1; c++) step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1 (timeout)", out_valid); else n_pass++;
        r0 = rd_n;
        for (int c = 0; c < 5; c++) begin
            step();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 32'hB000_0010 || out_port !== 2'd1)
                $display("FAIL bp_hold%0d: got valid %b data %h port %0d expected valid 1 data b0000010 port 1",
                         c, out_valid, out_data, out_port);
            else n_pass++;
        end
        n_total++; if (rd_n != r0) $display("FAIL bp_no_read: got %0d reads expected 0", rd_n - r0); else n_pass++;
        out_ready = 1'b1;
        wait_words(g0 + 2, 40, "bp_done");
        wait_idle(20, "bp_idle");
        n_total++;
        if (got_data[g0 % LOGSZ] !== 32'hB000_0010 || got_data[(g0 + 1) % LOGSZ] !== 32'hB000_0011 ||
            got_port[g0 % LOGSZ] !== 2'd1 || got_port[(g0 + 1) % LOGSZ] !== 2'd1)
            $display("FAIL bp_words: got %h/%0d %h/%0d expected b0000010/1 b0000011/1",
                     got_data[g0 % LOGSZ], got_port[g0 % LOGSZ], got_data[(g0 + 1) % LOGSZ], got_port[(g0 + 1) % LOGSZ]);
        else n_pass++;
    endtask

    // Reset while port 2's word waits in OUT; the next grant starts from port 0.
    task automatic test_reset_mid();
        int g0;
        sched_en = 1'b0; out_ready = 1'b0;
        push(2, 32'hDEAD_0002);
        sched_en = 1'b1;
        for (int c = 0; c < 20 && out_valid !== 1'b1; c++) step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid: got %b expected 1 (timeout)", out_valid); else n_pass++;
        sched_en = 1'b0;
        rst = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (fifo_rd_en !== 4'b0000) $display("FAIL rstmid_rd_en: got %b expected 0000", fifo_rd_en); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        rst = 1'b0;
        step();
        push(0, 32'h5000_0000);
        push(3, 32'h5000_0003);
        g0 = got_n;
        out_ready = 1'b1;
        sched_en = 1'b1;
        wait_words(g0 + 2, 40, "rstmid_done");
        wait_idle(20, "rstmid_idle");
        n_total++;
        if (got_port[g0 % LOGSZ] !== 2'd0 || got_data[g0 % LOGSZ] !== 32'h5000_0000 ||
            got_port[(g0 + 1) % LOGSZ] !== 2'd3 || got_data[(g0 + 1) % LOGSZ] !== 32'h5000_0003)
            $display("FAIL rstmid_order: got %0d:%h then %0d:%h expected 0:50000000 then 3:50000003",
                     got_port[g0 % LOGSZ], got_data[g0 % LOGSZ], got_port[(g0 + 1) % LOGSZ], got_data[(g0 + 1) % LOGSZ]);
        else n_pass++;
    endtask

`ifdef FIFO_SCHED_PRIO_EN
    // Fixed priority: port 0 drains (4 then 2 words) before port 3 is served.
    task automatic test_prio();
        int g0, idx;
        sched_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(0, mkw(8'h70, 0, k));
            push(3, mkw(8'h73, 3, k));
        end
        g0 = got_n;
        sched_en = 1'b1;
        wait_words(g0 + 12, 200, "prio_done");
        wait_idle(20, "prio_idle");
        idx = g0;
        for (int p = 0; p < N; p += 3) begin
            for (int k = 0; k < 6; k++) begin
                n_total++;
                if (got_port[idx % LOGSZ] !== LOGN'(p) || got_data[idx % LOGSZ] !== mkw((p == 0) ? 8'h70 : 8'h73, p, k))
                    $display("FAIL prio_word%0d: got port %0d data %h expected port %0d data %h", idx - g0,
                             got_port[idx % LOGSZ], got_data[idx % LOGSZ], p, mkw((p == 0) ? 8'h70 : 8'h73, p, k));
                else n_pass++;
                idx++;
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; sched_en = 1'b0; out_ready = 1'b0;
        test_reset();
`ifdef FIFO_SCHED_PRIO_EN
        test_reset_mid();
        test_prio();
`else
        test_all_ports();
        test_single_port();
        test_sched_en_drop();
        test_backpressure();
        test_reset_mid();
`endif
        n_total++; if (viol != 0) $display("FAIL rd_en_protocol: got %0d violations expected 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
